// File: rtl/axi_avb_pkg.sv
// rtl/axi_avb_pkg.sv - shared FSM encoding and AXI response constants for axi_avb_bridge
package axi_avb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        WR_RSP,
        RD_CMD,
        RD_WAIT,
        RD_RSP
    } state_t;

    localparam logic [1:0]  RESP_OKAY            = 2'b00;
    localparam logic [1:0]  RESP_SLVERR          = 2'b10;
    localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/axi_avb_bridge.sv
// rtl/axi_avb_bridge.sv - single-outstanding AXI4-Lite slave to Avalon-MM master bridge
// Optional read timeout enabled by defining AXI_AVB_BRIDGE_TIMEOUT_EN.
module axi_avb_bridge
    import axi_avb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] avb_address,
    output logic [3:0]  avb_byteenable,
    output logic        avb_read,
    output logic        avb_write,
    output logic [31:0] avb_writedata,
    input  logic [31:0] avb_readdata,
    input  logic        avb_readdatavalid,
    input  logic        avb_waitrequest
);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        wr_pair;

`ifdef AXI_AVB_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    // A write needs both address and data present; half a pair is never accepted.
    assign wr_pair = s_awvalid && s_wvalid;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
`ifdef AXI_AVB_BRIDGE_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (wr_pair) begin
                    state_d = WR_CMD;
                    addr_d  = s_awaddr;
                    wdata_d = s_wdata;
                    be_d    = s_wstrb;
                end else if (s_arvalid) begin
                    state_d = RD_CMD;
                    addr_d  = s_araddr;
                    be_d    = 4'hF;
                end
            end
            WR_CMD: if (!avb_waitrequest) state_d = WR_RSP;
            WR_RSP: if (s_bready) state_d = IDLE;
            RD_CMD: begin
                if (!avb_waitrequest) begin
                    state_d = RD_WAIT;
`ifdef AXI_AVB_BRIDGE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            RD_WAIT: begin
                if (avb_readdatavalid) begin
                    state_d = RD_RSP;
                    rdata_d = avb_readdata;
                    rresp_d = RESP_OKAY;
                end
`ifdef AXI_AVB_BRIDGE_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = RD_RSP;
                    rdata_d = TIMEOUT_DATA;
                    rresp_d = RESP_SLVERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RD_RSP: if (s_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'h0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
`ifdef AXI_AVB_BRIDGE_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
`ifdef AXI_AVB_BRIDGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Readies are decoded in IDLE so the handshake costs no extra cycle.
    assign s_awready      = (state_q == IDLE) && wr_pair;
    assign s_wready       = (state_q == IDLE) && wr_pair;
    assign s_arready      = (state_q == IDLE) && s_arvalid && !wr_pair;
    assign s_bvalid       = (state_q == WR_RSP);
    assign s_bresp        = RESP_OKAY;
    assign s_rvalid       = (state_q == RD_RSP);
    assign s_rdata        = rdata_q;
    assign s_rresp        = rresp_q;
    assign avb_write      = (state_q == WR_CMD);
    assign avb_read       = (state_q == RD_CMD);
    assign avb_address    = addr_q;
    assign avb_writedata  = wdata_q;
    assign avb_byteenable = be_q;

endmodule
